// File: rtl/pll_seq_pkg.sv
// Shared types for the PLL reset sequencer.
//   pll_seq_state_t : sequencer FSM states
//   max3            : largest of three counts, used to size the shared counter
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_seq_state_t;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for a level crossing into i_clk.
// Ports:
//   i_clk : destination clock
//   i_d   : asynchronous input level
//   o_q   : synchronised level, two i_clk edges behind i_d
module sync_2ff (
  input  logic i_clk,
  input  logic i_d,
  output logic o_q
);

  (* ASYNC_REG = "TRUE" *) logic r_meta_p0;
  (* ASYNC_REG = "TRUE" *) logic r_sync_p1;

  // Stage p0 may go metastable; stage p1 gives it a full cycle to resolve.
  always_ff @(posedge i_clk) begin
    r_meta_p0 <= i_d;
    r_sync_p1 <= r_meta_p0;
  end

  assign o_q = r_sync_p1;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Brings the system PLL out of reset and holds the design-wide reset until
// PLL lock has been continuously present for a qualification window.
// Re-sequences the PLL on lock loss or on request, with bounded retries and
// a sticky fault state. Runs on the PLL reference clock only.
// Ports:
//   clkin     : reference clock (only clock)
//   reset     : synchronous active-high reset
//   pll_lock  : raw PLL LOCK, asynchronous to clkin
//   restart   : one-cycle request to re-sequence the PLL
//   pll_reset : PLL reset pin, active-high
//   sys_reset : downstream reset, active-high
//   ready     : high while running on a qualified lock
//   fault     : high in the sticky fault state
//   lock_lost : one-cycle pulse when lock drops while running
//   retries   : lock timeouts in the current sequence
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RESET_CYCLES  = 16,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 3
) (
  input  logic                               clkin,
  input  logic                               reset,
  input  logic                               pll_lock,
  input  logic                               restart,
  output logic                               pll_reset,
  output logic                               sys_reset,
  output logic                               ready,
  output logic                               fault,
  output logic                               lock_lost,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retries
);

  localparam int unsigned CNT_MAX = max3(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);
  localparam int          RET_W   = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RET_W-1:0] RET_LIMIT    = RET_W'(MAX_RETRIES);

  logic             w_lock_s;

  pll_seq_state_t   r_state;
  pll_seq_state_t   w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [RET_W-1:0] r_retries;
  logic [RET_W-1:0] w_retries_nxt;
  logic [RET_W-1:0] w_retries_inc;
  logic             w_lock_lost_nxt;

  logic             w_pll_reset_nxt;
  logic             w_sys_reset_nxt;
  logic             w_ready_nxt;
  logic             w_fault_nxt;

  logic             r_pll_reset;
  logic             r_sys_reset;
  logic             r_ready;
  logic             r_fault;
  logic             r_lock_lost;

  sync_2ff u_lock_sync (
    .i_clk (clkin),
    .i_d   (pll_lock),
    .o_q   (w_lock_s)
  );

  // State register: FSM state, shared counter, retry count and outputs.
  always_ff @(posedge clkin) begin
    if (reset) begin
      r_state     <= RST_PLL;
      r_cnt       <= '0;
      r_retries   <= '0;
      r_pll_reset <= 1'b1;
      r_sys_reset <= 1'b1;
      r_ready     <= 1'b0;
      r_fault     <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retries   <= w_retries_nxt;
      r_pll_reset <= w_pll_reset_nxt;
      r_sys_reset <= w_sys_reset_nxt;
      r_ready     <= w_ready_nxt;
      r_fault     <= w_fault_nxt;
      r_lock_lost <= w_lock_lost_nxt;
    end
  end

  // Next-state logic. restart outranks everything below reset, so a restart
  // coinciding with lock loss in RUN does not raise lock_lost.
  always_comb begin
    w_state_nxt     = r_state;
    w_retries_nxt   = r_retries;
    w_retries_inc   = r_retries + 1'b1;
    w_lock_lost_nxt = 1'b0;

    if (restart) begin
      w_state_nxt   = RST_PLL;
      w_retries_nxt = '0;
    end else begin
      unique case (r_state)
        RST_PLL: begin
          if (r_cnt == RESET_LAST) w_state_nxt = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (w_lock_s) begin
            w_state_nxt = STABLE;
          end else if (r_cnt == TIMEOUT_LAST) begin
            w_retries_nxt = w_retries_inc;
            w_state_nxt   = (w_retries_inc == RET_LIMIT) ? FAULT : RST_PLL;
          end
        end
        STABLE: begin
          // Any drop during qualification restarts the window from WAIT_LOCK.
          if (!w_lock_s) begin
            w_state_nxt = WAIT_LOCK;
          end else if (r_cnt == STABLE_LAST) begin
            w_state_nxt   = RUN;
            w_retries_nxt = '0;
          end
        end
        RUN: begin
          if (!w_lock_s) begin
            w_state_nxt     = RST_PLL;
            w_lock_lost_nxt = 1'b1;
          end
        end
        FAULT: begin
          w_state_nxt = FAULT;
        end
        default: begin
          w_state_nxt = RST_PLL;
        end
      endcase
    end

    // Counter restarts on every state change and on restart (which also
    // re-arms the hold count while already in RST_PLL). It only needs to run
    // in the timed states.
    if (restart || (w_state_nxt != r_state)) begin
      w_cnt_nxt = '0;
    end else if (r_state inside {RUN, FAULT}) begin
      w_cnt_nxt = r_cnt;
    end else begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // Output decode from the next state, registered alongside the state so
  // outputs change on the same edge.
  always_comb begin
    w_pll_reset_nxt = (w_state_nxt == RST_PLL) || (w_state_nxt == FAULT);
    w_sys_reset_nxt = (w_state_nxt != RUN);
    w_ready_nxt     = (w_state_nxt == RUN);
    w_fault_nxt     = (w_state_nxt == FAULT);
  end

  assign pll_reset = r_pll_reset;
  assign sys_reset = r_sys_reset;
  assign ready     = r_ready;
  assign fault     = r_fault;
  assign lock_lost = r_lock_lost;
  assign retries   = r_retries;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer with RESET_CYCLES=4, LOCK_TIMEOUT=32,
// STABLE_CYCLES=8, MAX_RETRIES=2. Edge 0 of each scenario is the last edge
// with reset high; inputs change 1 time unit after an edge and outputs are
// sampled on the following falling edge.
module tb_pll_reset_sequencer;

  localparam int S_RST   = 0;
  localparam int S_WAIT  = 1;  // WAIT_LOCK and STABLE share outputs
  localparam int S_RUN   = 2;
  localparam int S_FAULT = 3;

  logic       clkin    = 1'b0;
  logic       reset    = 1'b1;
  logic       pll_lock = 1'b0;
  logic       restart  = 1'b0;
  logic       pll_reset;
  logic       sys_reset;
  logic       ready;
  logic       fault;
  logic       lock_lost;
  logic [1:0] retries;

  pll_reset_sequencer #(
    .RESET_CYCLES  (4),
    .LOCK_TIMEOUT  (32),
    .STABLE_CYCLES (8),
    .MAX_RETRIES   (2)
  ) dut (
    .clkin     (clkin),
    .reset     (reset),
    .pll_lock  (pll_lock),
    .restart   (restart),
    .pll_reset (pll_reset),
    .sys_reset (sys_reset),
    .ready     (ready),
    .fault     (fault),
    .lock_lost (lock_lost),
    .retries   (retries)
  );

  always #5 clkin = ~clkin;

  typedef struct {
    int         edge_no;
    logic [6:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Output vector layout: {pll_reset, sys_reset, ready, fault, lock_lost, retries}
  function automatic logic [6:0] exp_vec(input int st, input logic ll, input logic [1:0] rt);
    logic pr, sr, rd, ft;
    pr = (st == S_RST) || (st == S_FAULT);
    sr = (st != S_RUN);
    rd = (st == S_RUN);
    ft = (st == S_FAULT);
    return {pr, sr, rd, ft, ll, rt};
  endfunction

  task automatic apply_reset();
    reset    = 1'b1;
    restart  = 1'b0;
    pll_lock = 1'b0;
    repeat (3) @(posedge clkin);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    int   s;
    reset    = 1'b1;
    restart  = 1'b1;
    pll_lock = 1'b0;
    repeat (3) @(posedge clkin);
    #1;
    reset   = 1'b0;
    restart = 1'b0;
    sb.push_back('{0, exp_vec(S_RST, 1'b0, 2'd0)});
    for (int k = 0; k <= 6; k++) begin
      if (k < 6) begin
        s = (k + 1 <= 3) ? S_RST : S_WAIT;
        sb.push_back('{k + 1, exp_vec(s, 1'b0, 2'd0)});
      end
      @(negedge clkin);
      e = sb.pop_front();
      n_vec++;
      if ({pll_reset, sys_reset, ready, fault, lock_lost, retries} !== e.v) begin
        n_err++;
        $display("FAIL reset edge %0d: got %b expected %b", e.edge_no,
                 {pll_reset, sys_reset, ready, fault, lock_lost, retries}, e.v);
      end
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic test_bringup();
    exp_t e;
    int   s;
    apply_reset();
    sb.push_back('{0, exp_vec(S_RST, 1'b0, 2'd0)});
    for (int k = 0; k <= 26; k++) begin
      if (k == 10) pll_lock = 1'b1;
      if (k < 26) begin
        s = (k + 1 <= 3) ? S_RST : (k + 1 <= 20) ? S_WAIT : S_RUN;
        sb.push_back('{k + 1, exp_vec(s, 1'b0, 2'd0)});
      end
      @(negedge clkin);
      e = sb.pop_front();
      n_vec++;
      if ({pll_reset, sys_reset, ready, fault, lock_lost, retries} !== e.v) begin
        n_err++;
        $display("FAIL bringup edge %0d: got %b expected %b", e.edge_no,
                 {pll_reset, sys_reset, ready, fault, lock_lost, retries}, e.v);
      end
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    int   s;
    apply_reset();
    sb.push_back('{0, exp_vec(S_RST, 1'b0, 2'd0)});
    for (int k = 0; k <= 34; k++) begin
      if (k == 10) pll_lock = 1'b1;
      if (k == 15) pll_lock = 1'b0;
      if (k == 18) pll_lock = 1'b1;
      if (k < 34) begin
        s = (k + 1 <= 3) ? S_RST : (k + 1 <= 28) ? S_WAIT : S_RUN;
        sb.push_back('{k + 1, exp_vec(s, 1'b0, 2'd0)});
      end
      @(negedge clkin);
      e = sb.pop_front();
      n_vec++;
      if ({pll_reset, sys_reset, ready, fault, lock_lost, retries} !== e.v) begin
        n_err++;
        $display("FAIL glitch edge %0d: got %b expected %b", e.edge_no,
                 {pll_reset, sys_reset, ready, fault, lock_lost, retries}, e.v);
      end
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic test_timeout_fault();
    exp_t       e;
    int         s;
    logic [1:0] rt;
    apply_reset();
    sb.push_back('{0, exp_vec(S_RST, 1'b0, 2'd0)});
    for (int k = 0; k <= 275; k++) begin
      if (k < 275) begin
        if (k + 1 <= 3)       begin s = S_RST;   rt = 2'd0; end
        else if (k + 1 <= 35) begin s = S_WAIT;  rt = 2'd0; end
        else if (k + 1 <= 39) begin s = S_RST;   rt = 2'd1; end
        else if (k + 1 <= 71) begin s = S_WAIT;  rt = 2'd1; end
        else                  begin s = S_FAULT; rt = 2'd2; end
        sb.push_back('{k + 1, exp_vec(s, 1'b0, rt)});
      end
      @(negedge clkin);
      e = sb.pop_front();
      n_vec++;
      if ({pll_reset, sys_reset, ready, fault, lock_lost, retries} !== e.v) begin
        n_err++;
        $display("FAIL timeout edge %0d: got %b expected %b", e.edge_no,
                 {pll_reset, sys_reset, ready, fault, lock_lost, retries}, e.v);
      end
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic test_lock_loss();
    exp_t e;
    int   s;
    logic ll;
    apply_reset();
    sb.push_back('{0, exp_vec(S_RST, 1'b0, 2'd0)});
    for (int k = 0; k <= 45; k++) begin
      if (k == 10) pll_lock = 1'b1;
      if (k == 25) pll_lock = 1'b0;
      if (k == 30) pll_lock = 1'b1;
      if (k < 45) begin
        s  = (k + 1 <= 3)  ? S_RST  : (k + 1 <= 20) ? S_WAIT :
             (k + 1 <= 27) ? S_RUN  : (k + 1 <= 31) ? S_RST  :
             (k + 1 <= 40) ? S_WAIT : S_RUN;
        ll = (k + 1 == 28);
        sb.push_back('{k + 1, exp_vec(s, ll, 2'd0)});
      end
      @(negedge clkin);
      e = sb.pop_front();
      n_vec++;
      if ({pll_reset, sys_reset, ready, fault, lock_lost, retries} !== e.v) begin
        n_err++;
        $display("FAIL lock_loss edge %0d: got %b expected %b", e.edge_no,
                 {pll_reset, sys_reset, ready, fault, lock_lost, retries}, e.v);
      end
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic test_restart();
    exp_t       e;
    int         s;
    logic [1:0] rt;
    apply_reset();
    sb.push_back('{0, exp_vec(S_RST, 1'b0, 2'd0)});
    for (int k = 0; k <= 95; k++) begin
      if (k == 80) restart = 1'b1;
      if (k == 81) restart = 1'b0;
      if (k == 83) restart = 1'b1;
      if (k == 84) restart = 1'b0;
      if (k < 95) begin
        if (k + 1 <= 3)       begin s = S_RST;   rt = 2'd0; end
        else if (k + 1 <= 35) begin s = S_WAIT;  rt = 2'd0; end
        else if (k + 1 <= 39) begin s = S_RST;   rt = 2'd1; end
        else if (k + 1 <= 71) begin s = S_WAIT;  rt = 2'd1; end
        else if (k + 1 <= 80) begin s = S_FAULT; rt = 2'd2; end
        else if (k + 1 <= 87) begin s = S_RST;   rt = 2'd0; end
        else                  begin s = S_WAIT;  rt = 2'd0; end
        sb.push_back('{k + 1, exp_vec(s, 1'b0, rt)});
      end
      @(negedge clkin);
      e = sb.pop_front();
      n_vec++;
      if ({pll_reset, sys_reset, ready, fault, lock_lost, retries} !== e.v) begin
        n_err++;
        $display("FAIL restart edge %0d: got %b expected %b", e.edge_no,
                 {pll_reset, sys_reset, ready, fault, lock_lost, retries}, e.v);
      end
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic test_restart_beats_loss();
    exp_t e;
    int   s;
    apply_reset();
    sb.push_back('{0, exp_vec(S_RST, 1'b0, 2'd0)});
    for (int k = 0; k <= 35; k++) begin
      if (k == 10) pll_lock = 1'b1;
      if (k == 25) pll_lock = 1'b0;
      if (k == 27) restart  = 1'b1;
      if (k == 28) restart  = 1'b0;
      if (k < 35) begin
        s = (k + 1 <= 3)  ? S_RST : (k + 1 <= 20) ? S_WAIT :
            (k + 1 <= 27) ? S_RUN : (k + 1 <= 31) ? S_RST  : S_WAIT;
        sb.push_back('{k + 1, exp_vec(s, 1'b0, 2'd0)});
      end
      @(negedge clkin);
      e = sb.pop_front();
      n_vec++;
      if ({pll_reset, sys_reset, ready, fault, lock_lost, retries} !== e.v) begin
        n_err++;
        $display("FAIL restart_vs_loss edge %0d: got %b expected %b", e.edge_no,
                 {pll_reset, sys_reset, ready, fault, lock_lost, retries}, e.v);
      end
      @(posedge clkin);
      #1;
    end
  endtask

  task automatic test_reset_priority();
    exp_t e;
    int   s;
    apply_reset();
    sb.push_back('{0, exp_vec(S_RST, 1'b0, 2'd0)});
    for (int k = 0; k <= 35; k++) begin
      if (k == 10) pll_lock = 1'b1;
      if (k == 25) begin
        reset    = 1'b1;
        restart  = 1'b1;
        pll_lock = 1'b0;
      end
      if (k == 26) begin
        reset   = 1'b0;
        restart = 1'b0;
      end
      if (k < 35) begin
        s = (k + 1 <= 3)  ? S_RST : (k + 1 <= 20) ? S_WAIT :
            (k + 1 <= 25) ? S_RUN : (k + 1 <= 29) ? S_RST  : S_WAIT;
        sb.push_back('{k + 1, exp_vec(s, 1'b0, 2'd0)});
      end
      @(negedge clkin);
      e = sb.pop_front();
      n_vec++;
      if ({pll_reset, sys_reset, ready, fault, lock_lost, retries} !== e.v) begin
        n_err++;
        $display("FAIL reset_priority edge %0d: got %b expected %b", e.edge_no,
                 {pll_reset, sys_reset, ready, fault, lock_lost, retries}, e.v);
      end
      @(posedge clkin);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_glitch();
    test_timeout_fault();
    test_lock_loss();
    test_restart();
    test_restart_beats_loss();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
